// File: rtl/programmable_counting_element.sv
// Programmable down-counter with a selectable active field (low/high/full),
// binary or BCD decrement, and one-shot or periodic auto-reload modes.
module programmable_counting_element #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] initial_count,
  input  logic             load_new_count,
  input  logic             count_enable,
  input  logic             counter_programmed,
  input  logic             BCD,
  input  logic [1:0]       RW,
  input  logic             MODE,
  output logic [WIDTH-1:0] current_count,
  output logic             count_loaded,
  output logic             terminal_count,
  output logic             running
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int DIGITS = WIDTH / 4;

  localparam logic [WIDTH-1:0] LOW_MASK  = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] HIGH_MASK = ~LOW_MASK;
  localparam logic [WIDTH-1:0] FULL_MASK = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LOW_UNIT  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] HIGH_UNIT = LOW_UNIT << HALF;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_count;
  logic [WIDTH-1:0] field_mask;
  logic [WIDTH-1:0] field_unit;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] dec_next;
  logic             field_is_one;

  // Ripple-borrow decimal decrement restricted to digits selected by mask;
  // digits outside the field are never touched, so no borrow escapes it.
  function automatic logic [WIDTH-1:0] bcd_dec(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (mask[4*i] && borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    field_mask = FULL_MASK;
    field_unit = LOW_UNIT;
    case (RW)
      2'b01: begin
        field_mask = LOW_MASK;
        field_unit = LOW_UNIT;
      end
      2'b10: begin
        field_mask = HIGH_MASK;
        field_unit = HIGH_UNIT;
      end
      default: begin
        field_mask = FULL_MASK;
        field_unit = LOW_UNIT;
      end
    endcase
  end

  // Subtracting the field's unit and masking discards any borrow out of the field.
  assign bin_next     = (current_count & ~field_mask) | ((current_count - field_unit) & field_mask);
  assign dec_next     = BCD ? bcd_dec(current_count, field_mask) : bin_next;
  assign field_is_one = (current_count & field_mask) == field_unit;
  assign running      = (state == COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      current_count  <= '0;
      reload_count   <= '0;
      count_loaded   <= 1'b0;
      terminal_count <= 1'b0;
    end else if (counter_programmed) begin
      state          <= IDLE;
      count_loaded   <= 1'b0;
      terminal_count <= 1'b0;
    end else if (load_new_count) begin
      state          <= COUNT;
      current_count  <= initial_count;
      reload_count   <= initial_count;
      count_loaded   <= 1'b1;
      terminal_count <= 1'b0;
    end else if (state == COUNT) begin
      if (count_enable) begin
        if (field_is_one) begin
          terminal_count <= 1'b1;
          if (MODE) begin
            current_count <= (current_count & ~field_mask) | (reload_count & field_mask);
          end else begin
            current_count <= current_count & ~field_mask;
            state         <= DONE;
          end
        end else begin
          current_count  <= dec_next;
          terminal_count <= 1'b0;
        end
      end else begin
        terminal_count <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_programmable_counting_element.sv
// Randomized scoreboard bench: a driver issues stimulus and queues the expected
// outputs from an arithmetic reference model; a monitor pops and compares.
module tb_programmable_counting_element;

  logic        CLK;
  logic        RST;
  logic [15:0] initial_count;
  logic        load_new_count;
  logic        count_enable;
  logic        counter_programmed;
  logic        BCD;
  logic [1:0]  RW;
  logic        MODE;
  logic [15:0] current_count;
  logic        count_loaded;
  logic        terminal_count;
  logic        running;

  programmable_counting_element #(.WIDTH(16)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .initial_count     (initial_count),
    .load_new_count    (load_new_count),
    .count_enable      (count_enable),
    .counter_programmed(counter_programmed),
    .BCD               (BCD),
    .RW                (RW),
    .MODE              (MODE),
    .current_count     (current_count),
    .count_loaded      (count_loaded),
    .terminal_count    (terminal_count),
    .running           (running)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] cnt;
    logic        loaded;
    logic        tc;
    logic        run;
  } exp_t;

  typedef enum {S_IDLE, S_COUNT, S_DONE} mst_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [15:0] m_count;
  logic [15:0] m_reload;
  logic        m_loaded;
  logic        m_tc;
  mst_t        m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int field_bits(input logic [1:0] rw);
    return (rw == 2'b01 || rw == 2'b10) ? 8 : 16;
  endfunction

  function automatic int get_field(input logic [15:0] v, input logic [1:0] rw);
    case (rw)
      2'b01:   return int'(v[7:0]);
      2'b10:   return int'(v[15:8]);
      default: return int'(v);
    endcase
  endfunction

  function automatic logic [15:0] put_field(input logic [15:0] v, input logic [1:0] rw, input int f);
    logic [15:0] r;
    r = v;
    case (rw)
      2'b01:   r[7:0]  = 8'(f);
      2'b10:   r[15:8] = 8'(f);
      default: r       = 16'(f);
    endcase
    return r;
  endfunction

  // Decimal minus one: zero wraps to all nines; otherwise the lowest nonzero
  // digit drops by one and every zero digit below it becomes nine.
  function automatic int bcd_minus1(input int f, input int n);
    int r;
    int k;
    if (f == 0) begin
      r = 0;
      for (int j = 0; j < n / 4; j++) r = r * 16 + 9;
      return r;
    end
    k = 0;
    while (((f >> (4 * k)) & 15) == 0) k++;
    r = f - (1 << (4 * k));
    for (int j = 0; j < k; j++) r = r + (9 << (4 * j));
    return r;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic en, input logic prog,
                      input logic bcd, input logic [1:0] rw, input logic mode,
                      input logic [15:0] init);
    int   f;
    int   n;
    exp_t e;
    RST                = rst;
    load_new_count     = ld;
    count_enable       = en;
    counter_programmed = prog;
    BCD                = bcd;
    RW                 = rw;
    MODE               = mode;
    initial_count      = init;
    n = field_bits(rw);
    if (rst) begin
      m_count = '0; m_reload = '0; m_loaded = 1'b0; m_tc = 1'b0; m_st = S_IDLE;
    end else if (prog) begin
      m_st = S_IDLE; m_loaded = 1'b0; m_tc = 1'b0;
    end else if (ld) begin
      m_count = init; m_reload = init; m_loaded = 1'b1; m_tc = 1'b0; m_st = S_COUNT;
    end else if (m_st == S_COUNT) begin
      if (en) begin
        f = get_field(m_count, rw);
        if (f == 1) begin
          m_tc = 1'b1;
          if (mode) begin
            m_count = put_field(m_count, rw, get_field(m_reload, rw));
          end else begin
            m_count = put_field(m_count, rw, 0);
            m_st    = S_DONE;
          end
        end else begin
          m_tc = 1'b0;
          if (bcd) m_count = put_field(m_count, rw, bcd_minus1(f, n));
          else     m_count = put_field(m_count, rw, (f == 0) ? (1 << n) - 1 : f - 1);
        end
      end else begin
        m_tc = 1'b0;
      end
    end
    e.cnt    = m_count;
    e.loaded = m_loaded;
    e.tc     = m_tc;
    e.run    = (m_st == S_COUNT);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a fresh output set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("current_count",  32'(current_count),  32'(e.cnt));
        check("count_loaded",   32'(count_loaded),   32'(e.loaded));
        check("terminal_count", 32'(terminal_count), 32'(e.tc));
        check("running",        32'(running),        32'(e.run));
      end
    end
  end

  initial begin : driver
    logic [15:0] init;
    logic        r_bcd;
    logic [1:0]  r_rw;
    logic        r_mode;
    int          pulses;
    int          waited;

    // Reset state
    step(1, 0, 0, 0, 0, 2'b11, 0, 16'h0000);
    check("reset_count", 32'(current_count), 32'h0);
    check("reset_running", 32'(running), 32'h0);

    // Binary one-shot full width: 3 -> 2, 1, 0 then DONE
    step(0, 1, 0, 0, 0, 2'b11, 0, 16'h0003);
    repeat (4) step(0, 0, 1, 0, 0, 2'b11, 0, 16'h0000);
    check("oneshot_done_count", 32'(current_count), 32'h0000);
    check("oneshot_done_tc", 32'(terminal_count), 32'h1);
    check("oneshot_done_running", 32'(running), 32'h0);

    // BCD full width borrow and zero wrap
    step(0, 1, 0, 0, 1, 2'b11, 0, 16'h1000);
    step(0, 0, 1, 0, 1, 2'b11, 0, 16'h0000);
    check("bcd_1000", 32'(current_count), 32'h0999);
    step(0, 1, 0, 0, 1, 2'b11, 0, 16'h0000);
    step(0, 0, 1, 0, 1, 2'b11, 0, 16'h0000);
    check("bcd_0000", 32'(current_count), 32'h9999);

    // Field isolation in binary
    step(0, 1, 0, 0, 0, 2'b01, 0, 16'hAB00);
    step(0, 0, 1, 0, 0, 2'b01, 0, 16'h0000);
    check("low_field_wrap", 32'(current_count), 32'hABFF);
    step(0, 1, 0, 0, 0, 2'b10, 0, 16'h00CD);
    step(0, 0, 1, 0, 0, 2'b10, 0, 16'h0000);
    check("high_field_wrap", 32'(current_count), 32'hFFCD);

    // Periodic reload of 4 over 12 enabled cycles
    step(0, 1, 0, 0, 0, 2'b11, 1, 16'h0004);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0, 0, 2'b11, 1, 16'h0000);
      pulses += int'(terminal_count);
    end
    check("periodic_pulses", 32'(pulses), 32'd3);
    step(0, 0, 0, 0, 0, 2'b11, 1, 16'h0000);
    check("periodic_idle_tc", 32'(terminal_count), 32'h0);

    // Periodic with reload of 1 fires every enabled cycle
    step(0, 1, 0, 0, 0, 2'b11, 1, 16'h0001);
    repeat (3) step(0, 0, 1, 0, 0, 2'b11, 1, 16'h0000);
    check("reload_one_tc", 32'(terminal_count), 32'h1);

    // Program beats load; count is held
    step(0, 1, 0, 0, 0, 2'b11, 0, 16'h0050);
    repeat (2) step(0, 0, 1, 0, 0, 2'b11, 0, 16'h0000);
    step(0, 1, 0, 1, 0, 2'b11, 0, 16'h1234);
    check("prog_over_load_count", 32'(current_count), 32'h004E);
    check("prog_over_load_loaded", 32'(count_loaded), 32'h0);
    step(0, 0, 1, 0, 0, 2'b11, 0, 16'h0000);
    check("idle_ignores_enable", 32'(current_count), 32'h004E);

    // Reset mid-count
    step(0, 1, 0, 0, 0, 2'b11, 0, 16'h0777);
    step(0, 0, 1, 0, 0, 2'b11, 0, 16'h0000);
    step(1, 1, 1, 0, 0, 2'b11, 0, 16'h5555);
    check("rst_mid_count", 32'(current_count), 32'h0);

    // Randomized phase
    r_bcd = 1'b0; r_rw = 2'b11; r_mode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r_bcd  = 1'($urandom);
      if ($urandom_range(0, 19) == 0) r_rw   = 2'($urandom);
      if ($urandom_range(0, 19) == 0) r_mode = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       init = 16'($urandom);
        1:       init = 16'($urandom_range(0, 6));
        2:       init = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
        default: init = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      step(1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 39) == 0),
           r_bcd, r_rw, r_mode, init);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/programmable_counting_element.md
PROGRAMMABLE_COUNTING_ELEMENT -- requirements
Module: programmable_counting_element

Interface
REQ-001 Parameter WIDTH, default 16, SHALL be the counter width; legal values are multiples of 8, minimum 8.
REQ-002 Parameter HALF, default WIDTH/2, SHALL be the low/high field split point; it is derived and not overridden.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be a synchronous, active-high reset.
REQ-005 initial_count  input  WIDTH  SHALL be the count value captured on load_new_count.
REQ-006 load_new_count  input  1  SHALL request a load of initial_count.
REQ-007 count_enable  input  1  SHALL permit one decrement per cycle while counting.
REQ-008 counter_programmed  input  1  SHALL invalidate the loaded count (control-word write).
REQ-009 BCD  input  1  SHALL select decimal decrement when 1 and binary decrement when 0.
REQ-010 RW  input  2  SHALL select the active field: 01 = low HALF bits; 10 = high HALF bits; 11 or 00 = full WIDTH.
REQ-011 MODE  input  1  SHALL select the count mode: 0 = one-shot; 1 = periodic auto-reload.
REQ-012 current_count  output  WIDTH  SHALL present the registered count value.
REQ-013 count_loaded  output  1  SHALL be high when a valid count is held.
REQ-014 terminal_count  output  1  SHALL be the registered terminal-count indication.
REQ-015 running  output  1  SHALL be high in state COUNT.

Function
REQ-016 The block SHALL implement states IDLE, COUNT and DONE.
REQ-017 Per-cycle priority SHALL be RST > counter_programmed > load_new_count > count_enable.
REQ-018 On counter_programmed the block SHALL enter IDLE, set count_loaded=0 and terminal_count=0, and hold current_count.
REQ-019 On load_new_count the block SHALL copy initial_count to current_count and to an internal reload register, set count_loaded=1, set terminal_count=0, and enter COUNT from any state; the first decrement occurs the following cycle at the earliest.
REQ-020 In IDLE or DONE, count_enable SHALL be ignored.
REQ-021 In COUNT with count_enable=1, only the active field SHALL change; inactive bits hold, and no borrow crosses the field boundary.
REQ-022 Binary decrement SHALL be the active field minus 1, modulo 2^fieldwidth; 0 wraps to all ones.
REQ-023 BCD decrement SHALL be per 4-bit digit with ripple borrow: a digit of 0 becomes 9 and borrows; any other digit d becomes d-1 and stops the borrow, including illegal digits >9.
REQ-024 An active field of all-zero digits in BCD SHALL wrap to all 9s; in binary it SHALL wrap to all 1s. An initial count of 0 therefore gives the full range: 2^fieldwidth steps in binary, 10^(fieldwidth/4) in BCD.
REQ-025 The terminal event SHALL be count_enable=1 in COUNT with the active field equal to 1.
REQ-026 One-shot (MODE=0): the terminal event SHALL write 0 to the active field, set terminal_count=1 in the same edge, and enter DONE; terminal_count holds until a load, counter_programmed or RST.
REQ-027 Periodic (MODE=1): the terminal event SHALL write the reload register's active field instead of 0, pulse terminal_count high for exactly one cycle, and remain in COUNT.
REQ-028 Periodic with reload field = 1 SHALL produce terminal_count high on every enabled cycle.
REQ-029 MODE, BCD and RW SHALL be sampled every cycle; a change mid-count takes effect on the next decrement without reloading.
REQ-030 When count_enable=0 in COUNT, the state SHALL hold and terminal_count SHALL be 0 in periodic mode.

Reset
REQ-031 RST SHALL force current_count=0, the reload register to 0, count_loaded=0, terminal_count=0, running=0 and state IDLE, overriding every other input including mid-count.

Verification
REQ-032 WIDTH=16, binary, RW=11, MODE=0: load 0x0003, enable held -> counts 2, 1, 0; terminal_count=1 on the edge reaching 0; DONE holds 0x0000 with running=0.
REQ-033 BCD=1, RW=11: load 0x1000, one enable -> 0x0999; load 0x0000, one enable -> 0x9999.
REQ-034 RW=01, BCD=0: load 0xAB00, one enable -> 0xABFF (high byte unchanged); RW=10: load 0x00CD, one enable -> 0xFFCD.
REQ-035 MODE=1, load 0x0004, enable held 12 cycles -> terminal_count single-cycle pulses every 4th cycle; count sequence 3, 2, 1, 4, 3, ...
REQ-036 counter_programmed and load_new_count asserted in the same cycle -> count_loaded=0, state IDLE, current_count unchanged; RST asserted mid-count -> all outputs 0 next cycle.
